// File: rtl/qdec_ctx_arb.sv
// qdec_ctx_arb: controller/arbiter for the single-port CABAC context memory.
// Runs the slice-start context initialisation sweep, then shares the memory
// port between the context read requester and the state-update writer.
module qdec_ctx_arb #(
  parameter int ADDR_W    = 10,
  parameter int NUM_CTX   = 1024,
  parameter int MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic [ADDR_W-1:0] init_idx,
  input  logic [6:0]        init_val,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_vld,
  output logic              rd_rdy,
  output logic [6:0]        rd_data,
  output logic              rd_data_vld,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [6:0]        upd_data,
  input  logic              upd_vld,
  output logic              upd_rdy,
  output logic [ADDR_W-1:0] ctx_addr,
  output logic [7:0]        ctx_wdata,
  output logic              ctx_we,
  output logic              ctx_re,
  input  logic [7:0]        ctx_rdata,
  output logic              err_addr
);

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  localparam int                SW        = $clog2(MAX_STALL + 2);
  localparam logic [ADDR_W:0]   CTX_LIM   = (ADDR_W+1)'(NUM_CTX);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_CTX - 1);
  localparam logic [SW-1:0]     STALL_LIM = SW'(MAX_STALL);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [SW-1:0]     stall_cnt;
  logic              rd_pend;
  logic              rd_pend_oor;
  logic [6:0]        rd_hold;
  logic              rd_oor;
  logic              upd_oor;
  logic              force_rd;
  logic              rd_grant;
  logic              upd_grant;
  logic              rdata_unused;

  assign rd_oor       = {1'b0, rd_addr}  >= CTX_LIM;
  assign upd_oor      = {1'b0, upd_addr} >= CTX_LIM;
  assign force_rd     = (state == RUN) && (stall_cnt == STALL_LIM);
  assign rd_grant     = rd_vld && rd_rdy;
  assign upd_grant    = upd_vld && upd_rdy;
  assign init_busy    = (state == INIT);
  assign init_idx     = cnt;
  assign rd_data_vld  = rd_pend;
  assign rdata_unused = ctx_rdata[7];

  // Read data arrives straight from memory in the cycle after the grant and
  // is held afterwards; out-of-range reads return zero.
  assign rd_data = rd_pend ? (rd_pend_oor ? '0 : ctx_rdata[6:0]) : rd_hold;

  // Port arbitration: init sweep, else update-over-read with starvation override.
  always_comb begin
    rd_rdy    = 1'b0;
    upd_rdy   = 1'b0;
    ctx_addr  = '0;
    ctx_wdata = '0;
    ctx_we    = 1'b0;
    ctx_re    = 1'b0;
    case (state)
      INIT: begin
        ctx_we    = 1'b1;
        ctx_addr  = cnt;
        ctx_wdata = {1'b0, init_val};
      end
      RUN: begin
        upd_rdy = !force_rd;
        rd_rdy  = force_rd || !upd_vld;
        if (upd_vld && upd_rdy) begin
          ctx_addr  = upd_addr;
          ctx_wdata = {1'b0, upd_data};
          ctx_we    = !upd_oor;
        end else if (rd_vld && rd_rdy) begin
          ctx_addr = rd_addr;
          ctx_re   = !rd_oor;
        end
      end
      default: ;
    endcase
  end

  // Controller state, init counter, stall counter, read pipeline and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stall_cnt   <= '0;
      init_done   <= 1'b0;
      rd_pend     <= 1'b0;
      rd_pend_oor <= 1'b0;
      rd_hold     <= '0;
      err_addr    <= 1'b0;
    end else begin
      init_done   <= 1'b0;
      rd_pend     <= rd_grant;
      rd_pend_oor <= rd_oor;
      if (rd_pend)
        rd_hold <= rd_data;
      if ((rd_grant && rd_oor) || (upd_grant && upd_oor))
        err_addr <= 1'b1;
      if ((state == RUN) && rd_vld && !rd_grant)
        stall_cnt <= stall_cnt + 1'b1;
      else
        stall_cnt <= '0;
      case (state)
        IDLE: begin
          if (init_start) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        INIT: begin
          if (cnt == LAST_IDX) begin
            state     <= RUN;
            cnt       <= '0;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // A read granted in this cycle still completes via rd_pend.
          if (init_start) begin
            state <= INIT;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qdec_ctx_arb.sv
// tb_qdec_ctx_arb: directed test of qdec_ctx_arb with an 8-entry context
// memory model and an init table returning index+3.
module tb_qdec_ctx_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_start;
  logic       init_busy;
  logic       init_done;
  logic [3:0] init_idx;
  logic [6:0] init_val;
  logic [3:0] rd_addr;
  logic       rd_vld;
  logic       rd_rdy;
  logic [6:0] rd_data;
  logic       rd_data_vld;
  logic [3:0] upd_addr;
  logic [6:0] upd_data;
  logic       upd_vld;
  logic       upd_rdy;
  logic [3:0] ctx_addr;
  logic [7:0] ctx_wdata;
  logic       ctx_we;
  logic       ctx_re;
  logic [7:0] ctx_rdata = 8'h00;
  logic       err_addr;

  logic [7:0] mem [16];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign init_val = 7'(init_idx) + 7'd3;

  // Single-port memory model with one-cycle read latency.
  always @(posedge clk) begin
    if (ctx_we) mem[ctx_addr] <= ctx_wdata;
    if (ctx_re) ctx_rdata <= mem[ctx_addr];
  end

  qdec_ctx_arb #(.ADDR_W(4), .NUM_CTX(8), .MAX_STALL(4)) dut (
    .clk(clk), .rst(rst), .init_start(init_start), .init_busy(init_busy),
    .init_done(init_done), .init_idx(init_idx), .init_val(init_val),
    .rd_addr(rd_addr), .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_data(rd_data),
    .rd_data_vld(rd_data_vld), .upd_addr(upd_addr), .upd_data(upd_data),
    .upd_vld(upd_vld), .upd_rdy(upd_rdy), .ctx_addr(ctx_addr),
    .ctx_wdata(ctx_wdata), .ctx_we(ctx_we), .ctx_re(ctx_re),
    .ctx_rdata(ctx_rdata), .err_addr(err_addr)
  );

  task automatic drive_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample_point;
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    init_start = 1'b0;
    rd_vld = 1'b0; rd_addr = '0;
    upd_vld = 1'b0; upd_addr = '0; upd_data = '0;
  endtask

  task automatic test_reset;
    logic [30:0] got;
    drive_cycle();
    rst = 1'b1;
    clear_inputs();
    drive_cycle();
    rd_vld = 1'b1; upd_vld = 1'b1; rd_addr = 4'd2; upd_addr = 4'd3;
    sample_point();
    got = {init_busy, init_done, init_idx, rd_rdy, upd_rdy, rd_data, rd_data_vld,
           ctx_addr, ctx_wdata, ctx_we, ctx_re, err_addr};
    checks++;
    if (got !== 31'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", got);
    end
    drive_cycle();
    rst = 1'b0;
    sample_point();
    checks++;
    if ({rd_rdy, upd_rdy, ctx_we, ctx_re} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_no_grant: got %b expected 0000", {rd_rdy, upd_rdy, ctx_we, ctx_re});
    end
    clear_inputs();
  endtask

  task automatic test_init;
    logic [20:0] got, exp;
    drive_cycle();
    init_start = 1'b1;
    rd_vld = 1'b1; upd_vld = 1'b1;
    sample_point();
    checks++;
    if (init_busy !== 1'b0) begin
      failures++;
      $display("FAIL init_busy_cycle0: got %b expected 0", init_busy);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle();
      init_start = 1'b0;
      sample_point();
      got = {ctx_we, ctx_re, ctx_addr, ctx_wdata, init_idx, init_busy, init_done, rd_rdy, upd_rdy};
      exp = {1'b1, 1'b0, 4'(i), 8'(i + 3), 4'(i), 1'b1, 1'b0, 1'b0, 1'b0};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL init_sweep[%0d]: got %h expected %h", i, got, exp);
      end
    end
    drive_cycle();
    rd_vld = 1'b0; upd_vld = 1'b0;
    sample_point();
    checks++;
    if ({init_done, init_busy, upd_rdy, rd_rdy, ctx_we} !== 5'b10110) begin
      failures++;
      $display("FAIL init_done_pulse: got %b expected 10110",
               {init_done, init_busy, upd_rdy, rd_rdy, ctx_we});
    end
    drive_cycle();
    sample_point();
    checks++;
    if (init_done !== 1'b0) begin
      failures++;
      $display("FAIL init_done_single: got %b expected 0", init_done);
    end
  endtask

  task automatic test_rw_order;
    drive_cycle();
    rd_vld = 1'b1; rd_addr = 4'd5;
    upd_vld = 1'b1; upd_addr = 4'd5; upd_data = 7'h2A;
    sample_point();
    checks++;
    if ({upd_rdy, rd_rdy, ctx_we, ctx_re, ctx_addr, ctx_wdata} !== {4'b1010, 4'd5, 8'h2A}) begin
      failures++;
      $display("FAIL rw_write_first: got %h expected %h",
               {upd_rdy, rd_rdy, ctx_we, ctx_re, ctx_addr, ctx_wdata}, {4'b1010, 4'd5, 8'h2A});
    end
    drive_cycle();
    upd_vld = 1'b0;
    sample_point();
    checks++;
    if ({rd_rdy, ctx_re, ctx_we, ctx_addr} !== {3'b110, 4'd5}) begin
      failures++;
      $display("FAIL rw_read_next: got %h expected %h", {rd_rdy, ctx_re, ctx_we, ctx_addr}, {3'b110, 4'd5});
    end
    drive_cycle();
    rd_vld = 1'b0;
    sample_point();
    checks++;
    if ({rd_data_vld, rd_data} !== {1'b1, 7'h2A}) begin
      failures++;
      $display("FAIL rw_read_data: got %h expected %h", {rd_data_vld, rd_data}, {1'b1, 7'h2A});
    end
    drive_cycle();
    sample_point();
    checks++;
    if ({rd_data_vld, rd_data} !== {1'b0, 7'h2A}) begin
      failures++;
      $display("FAIL rw_data_hold: got %h expected %h", {rd_data_vld, rd_data}, {1'b0, 7'h2A});
    end
  endtask

  task automatic test_back_to_back;
    drive_cycle();
    rd_vld = 1'b1; rd_addr = 4'd2;
    sample_point();
    checks++;
    if ({ctx_re, ctx_addr} !== {1'b1, 4'd2}) begin
      failures++;
      $display("FAIL b2b_grant0: got %h expected %h", {ctx_re, ctx_addr}, {1'b1, 4'd2});
    end
    drive_cycle();
    rd_addr = 4'd7;
    sample_point();
    checks++;
    if ({ctx_re, ctx_addr, rd_data_vld, rd_data} !== {1'b1, 4'd7, 1'b1, 7'd5}) begin
      failures++;
      $display("FAIL b2b_grant1: got %h expected %h",
               {ctx_re, ctx_addr, rd_data_vld, rd_data}, {1'b1, 4'd7, 1'b1, 7'd5});
    end
    drive_cycle();
    rd_vld = 1'b0;
    sample_point();
    checks++;
    if ({rd_data_vld, rd_data} !== {1'b1, 7'd10}) begin
      failures++;
      $display("FAIL b2b_data1: got %h expected %h", {rd_data_vld, rd_data}, {1'b1, 7'd10});
    end
  endtask

  task automatic test_starvation;
    for (int c = 1; c <= 4; c++) begin
      drive_cycle();
      rd_vld = 1'b1; rd_addr = 4'd1;
      upd_vld = 1'b1; upd_addr = 4'd6; upd_data = 7'(c);
      sample_point();
      checks++;
      if ({rd_rdy, upd_rdy, ctx_we, ctx_re, ctx_addr} !== {4'b0110, 4'd6}) begin
        failures++;
        $display("FAIL starve_lose[%0d]: got %h expected %h", c,
                 {rd_rdy, upd_rdy, ctx_we, ctx_re, ctx_addr}, {4'b0110, 4'd6});
      end
    end
    drive_cycle();
    sample_point();
    checks++;
    if ({rd_rdy, upd_rdy, ctx_we, ctx_re, ctx_addr} !== {4'b1001, 4'd1}) begin
      failures++;
      $display("FAIL starve_force: got %h expected %h",
               {rd_rdy, upd_rdy, ctx_we, ctx_re, ctx_addr}, {4'b1001, 4'd1});
    end
    drive_cycle();
    rd_vld = 1'b0;
    sample_point();
    checks++;
    if ({upd_rdy, ctx_we, rd_data_vld, rd_data} !== {3'b111, 7'd4}) begin
      failures++;
      $display("FAIL starve_resume: got %h expected %h",
               {upd_rdy, ctx_we, rd_data_vld, rd_data}, {3'b111, 7'd4});
    end
    drive_cycle();
    clear_inputs();
  endtask

  task automatic test_out_of_range;
    drive_cycle();
    rd_vld = 1'b1; rd_addr = 4'd9;
    sample_point();
    checks++;
    if ({rd_rdy, ctx_re, err_addr} !== 3'b100) begin
      failures++;
      $display("FAIL oor_read_grant: got %b expected 100", {rd_rdy, ctx_re, err_addr});
    end
    drive_cycle();
    rd_vld = 1'b0;
    upd_vld = 1'b1; upd_addr = 4'd12; upd_data = 7'h11;
    sample_point();
    checks++;
    if ({rd_data_vld, rd_data, err_addr, upd_rdy, ctx_we} !== {1'b1, 7'd0, 3'b110}) begin
      failures++;
      $display("FAIL oor_read_data_write: got %h expected %h",
               {rd_data_vld, rd_data, err_addr, upd_rdy, ctx_we}, {1'b1, 7'd0, 3'b110});
    end
    drive_cycle();
    clear_inputs();
    sample_point();
    checks++;
    if (err_addr !== 1'b1) begin
      failures++;
      $display("FAIL oor_err_sticky: got %b expected 1", err_addr);
    end
  endtask

  task automatic test_reinit_after_read;
    drive_cycle();
    rd_vld = 1'b1; rd_addr = 4'd3; init_start = 1'b1;
    sample_point();
    checks++;
    if ({rd_rdy, ctx_re, ctx_addr} !== {2'b11, 4'd3}) begin
      failures++;
      $display("FAIL reinit_grant: got %h expected %h", {rd_rdy, ctx_re, ctx_addr}, {2'b11, 4'd3});
    end
    drive_cycle();
    init_start = 1'b0; rd_addr = 4'd4;
    sample_point();
    checks++;
    if ({ctx_we, ctx_addr, init_busy, rd_rdy, rd_data_vld, rd_data} !== {1'b1, 4'd0, 3'b101, 7'd6}) begin
      failures++;
      $display("FAIL reinit_first: got %h expected %h",
               {ctx_we, ctx_addr, init_busy, rd_rdy, rd_data_vld, rd_data}, {1'b1, 4'd0, 3'b101, 7'd6});
    end
    for (int i = 1; i < 8; i++) begin
      drive_cycle();
      sample_point();
      checks++;
      if ({rd_rdy, ctx_addr} !== {1'b0, 4'(i)}) begin
        failures++;
        $display("FAIL reinit_hold[%0d]: got %h expected %h", i, {rd_rdy, ctx_addr}, {1'b0, 4'(i)});
      end
    end
    drive_cycle();
    sample_point();
    checks++;
    if ({init_done, rd_rdy, ctx_re, ctx_addr} !== {3'b111, 4'd4}) begin
      failures++;
      $display("FAIL reinit_done_read: got %h expected %h", {init_done, rd_rdy, ctx_re, ctx_addr}, {3'b111, 4'd4});
    end
    drive_cycle();
    rd_vld = 1'b0;
    sample_point();
    checks++;
    if ({rd_data_vld, rd_data} !== {1'b1, 7'd7}) begin
      failures++;
      $display("FAIL reinit_read_data: got %h expected %h", {rd_data_vld, rd_data}, {1'b1, 7'd7});
    end
  endtask

  task automatic test_reset_mid_init;
    logic [30:0] got;
    drive_cycle();
    init_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle();
      init_start = 1'b0;
    end
    drive_cycle();
    rst = 1'b1;
    sample_point();
    checks++;
    if ({ctx_we, ctx_addr} !== {1'b1, 4'd3}) begin
      failures++;
      $display("FAIL rst_init_at3: got %h expected %h", {ctx_we, ctx_addr}, {1'b1, 4'd3});
    end
    drive_cycle();
    rst = 1'b0;
    upd_vld = 1'b1; upd_addr = 4'd1;
    sample_point();
    got = {init_busy, init_done, init_idx, rd_rdy, upd_rdy, rd_data, rd_data_vld,
           ctx_addr, ctx_wdata, ctx_we, ctx_re, err_addr};
    checks++;
    if (got !== 31'd0) begin
      failures++;
      $display("FAIL rst_mid_init_outputs: got %h expected 0", got);
    end
    drive_cycle();
    upd_vld = 1'b0;
    init_start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cycle();
      init_start = (i == 4);
      sample_point();
      checks++;
      if ({ctx_we, ctx_addr, init_idx} !== {1'b1, 4'(i), 4'(i)}) begin
        failures++;
        $display("FAIL restart_sweep[%0d]: got %h expected %h", i, {ctx_we, ctx_addr, init_idx}, {1'b1, 4'(i), 4'(i)});
      end
    end
    drive_cycle();
    init_start = 1'b0;
    sample_point();
    checks++;
    if ({init_done, init_busy} !== 2'b10) begin
      failures++;
      $display("FAIL restart_done: got %b expected 10", {init_done, init_busy});
    end
  endtask

  task automatic test_reset_inflight_read;
    drive_cycle();
    rd_vld = 1'b1; rd_addr = 4'd2; rst = 1'b1;
    sample_point();
    checks++;
    if (ctx_re !== 1'b1) begin
      failures++;
      $display("FAIL inflight_grant: got %b expected 1", ctx_re);
    end
    drive_cycle();
    rst = 1'b0; rd_vld = 1'b0;
    sample_point();
    checks++;
    if ({rd_data_vld, rd_data} !== 8'd0) begin
      failures++;
      $display("FAIL inflight_abort: got %h expected 0", {rd_data_vld, rd_data});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_init();
    test_rw_order();
    test_back_to_back();
    test_starvation();
    test_out_of_range();
    test_reinit_after_read();
    test_reset_mid_init();
    test_reset_inflight_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
